// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch datapath and its control FSM.
package stopwatch_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned DEC_MAX      = 9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } sw_state_t;

  // Next value of a digit that counts 0..max and then wraps to 0.
  function automatic bcd_t bcd_next(input bcd_t cur, input int unsigned max);
    if (cur == BCD_W'(max)) begin
      return '0;
    end
    return cur + BCD_W'(1);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..MAX; carry_out flags the increment that wraps it.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = DEC_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t digit,
  output logic carry_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= bcd_next(digit, MAX);
    end
  end

  // Combinational so the whole chain ripples within the advancing cycle.
  assign carry_out = inc && (digit == BCD_W'(MAX));

endmodule

// File: rtl/stopwatch_time_counter.sv
// Elapsed-time counter: prescaler to 1 s ticks feeding a BCD MM:SS digit chain.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic sec_tick,
  output logic wrap
);

  localparam int unsigned CNT_W   = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
  localparam int unsigned PRE_MAX = (TICK_DIV == 0) ? 0 : TICK_DIV - 1;

  logic [CNT_W-1:0] pre;
  logic             adv_c;
  logic             so_carry_c;
  logic             st_carry_c;
  logic             mo_carry_c;
  logic             mt_carry_c;

  // clear outranks count_en, so an advance is never generated while clearing.
  assign adv_c = count_en && !clear && (pre == CNT_W'(PRE_MAX));

  // Prescaler keeps its partial count whenever count_en drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (count_en) begin
      if (adv_c) begin
        pre <= '0;
      end else begin
        pre <= pre + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_tick <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      sec_tick <= adv_c;
      wrap     <= mt_carry_c;
    end
  end

  bcd_digit_counter #(.MAX(DEC_MAX)) u_sec_ones (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .inc       (adv_c),
    .digit     (sec_ones),
    .carry_out (so_carry_c)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .inc       (so_carry_c),
    .digit     (sec_tens),
    .carry_out (st_carry_c)
  );

  bcd_digit_counter #(.MAX(DEC_MAX)) u_min_ones (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .inc       (st_carry_c),
    .digit     (min_ones),
    .carry_out (mo_carry_c)
  );

  // Carry out of the top digit marks the 99:59 -> 00:00 rollover.
  bcd_digit_counter #(.MAX(DEC_MAX)) u_min_tens (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .inc       (mo_carry_c),
    .digit     (min_tens),
    .carry_out (mt_carry_c)
  );

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter with a 4-cycle second.
module tb_stopwatch_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       count_en = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       sec_tick, wrap;
  logic [15:0] cur_time;

  int checks = 0;
  int errors = 0;

  stopwatch_time_counter #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .clear    (clear),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .sec_tick (sec_tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  assign cur_time = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n posedges and land 1 time unit after the last one.
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    run(1);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    run(2);
    chk("rst_time", cur_time, 16'h0000);
    chk("rst_tick", 16'(sec_tick), 16'h0000);
    chk("rst_wrap", 16'(wrap), 16'h0000);
    rst = 1'b0;

    // 1: first second lands on the 4th enabled edge
    count_en = 1'b1;
    run(3);
    chk("t1_edge3_time", cur_time, 16'h0000);
    chk("t1_edge3_tick", 16'(sec_tick), 16'h0000);
    run(1);
    chk("t1_edge4_time", cur_time, 16'h0001);
    chk("t1_edge4_tick", 16'(sec_tick), 16'h0001);
    chk("t1_edge4_wrap", 16'(wrap), 16'h0000);
    run(1);
    chk("t1_edge5_tick", 16'(sec_tick), 16'h0000);
    chk("t1_edge5_time", cur_time, 16'h0001);

    // 2: seconds carry into minutes
    do_clear();
    chk("t2_clear_time", cur_time, 16'h0000);
    run(236);
    chk("t2_59s", cur_time, 16'h0059);
    run(4);
    chk("t2_1min", cur_time, 16'h0100);
    chk("t2_1min_tick", 16'(sec_tick), 16'h0001);

    // 3: pause keeps the partial second
    do_clear();
    run(2);
    count_en = 1'b0;
    run(1);
    chk("t3_pause_start", cur_time, 16'h0000);
    run(9);
    chk("t3_pause_end", cur_time, 16'h0000);
    chk("t3_pause_tick", 16'(sec_tick), 16'h0000);
    count_en = 1'b1;
    run(1);
    chk("t3_en3", cur_time, 16'h0000);
    run(1);
    chk("t3_en4", cur_time, 16'h0001);
    chk("t3_en4_tick", 16'(sec_tick), 16'h0001);

    // 4: full rollover 99:59 -> 00:00
    do_clear();
    run(23996);
    chk("t4_9959", cur_time, 16'h9959);
    chk("t4_9959_wrap", 16'(wrap), 16'h0000);
    run(3);
    chk("t4_pre3", cur_time, 16'h9959);
    run(1);
    chk("t4_rollover", cur_time, 16'h0000);
    chk("t4_wrap", 16'(wrap), 16'h0001);
    chk("t4_wrap_tick", 16'(sec_tick), 16'h0001);
    run(1);
    chk("t4_wrap_pulse", 16'(wrap), 16'h0000);

    // 5: clear beats count_en at pre=3
    do_clear();
    run(31);
    chk("t5_0007", cur_time, 16'h0007);
    clear = 1'b1;
    run(1);
    clear = 1'b0;
    chk("t5_clr_time", cur_time, 16'h0000);
    chk("t5_clr_tick", 16'(sec_tick), 16'h0000);
    run(3);
    chk("t5_pre_zeroed", cur_time, 16'h0000);
    run(1);
    chk("t5_0001", cur_time, 16'h0001);

    // 6: async reset between edges at 12:34
    do_clear();
    run(3016);
    chk("t6_1234", cur_time, 16'h1234);
    chk("t6_1234_tick", 16'(sec_tick), 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_time", cur_time, 16'h0000);
    chk("t6_async_tick", 16'(sec_tick), 16'h0000);
    run(1);
    chk("t6_held_time", cur_time, 16'h0000);
    rst = 1'b0;
    run(3);
    chk("t6_restart3", cur_time, 16'h0000);
    run(1);
    chk("t6_restart4", cur_time, 16'h0001);
    chk("t6_restart_wrap", 16'(wrap), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
